// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: SEXT / ZEXT / UPPER / BRANCH modes behind a
// registered output stage with a one-entry skid buffer. Optional counter: IMMEXT_COUNT_EN.
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef IMMEXT_COUNT_EN
   output logic [CNT_W-1:0] out_count,
`endif
   output logic [OUT_W-1:0] out_data
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; a producer holds valid and its payload stable until it transfers.
   localparam logic [1:0] MODE_SEXT   = 2'b00;
   localparam logic [1:0] MODE_ZEXT   = 2'b01;
   localparam logic [1:0] MODE_UPPER  = 2'b10;
   localparam logic [1:0] MODE_BRANCH = 2'b11;

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q,  out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [OUT_W-1:0] skid_data_q,  skid_data_d;
   logic             accept, drain;
   logic [OUT_W-1:0] sext_val, zext_val, ext_val;

   assign sext_val = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
   assign zext_val = {{(OUT_W-IN_W){1'b0}}, in_imm};

   always_comb begin
      ext_val = sext_val;
      case (in_mode)
         MODE_SEXT:   ext_val = sext_val;
         MODE_ZEXT:   ext_val = zext_val;
         MODE_UPPER:  ext_val = zext_val << IN_W;
         MODE_BRANCH: ext_val = sext_val << 2;
         default:     ext_val = sext_val;
      endcase
   end

   // Ready depends only on registered state, so there is no path from out_ready.
   assign in_ready = !skid_valid_q && !reset;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid_q && out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!out_valid_q || drain) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
            if (accept) begin
               skid_valid_d = 1'b1;
               skid_data_d  = ext_val;
            end
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = ext_val;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = ext_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef IMMEXT_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating count of accepted immediates.
   always_comb begin
      cnt_d = cnt_q;
      if (accept && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign out_count = cnt_q;
`endif

endmodule
